mode_select: RTL
================

// Module: mode_select
// PURPOSE
//  Front-panel mode sequencer for the digital clock (mode 0 = time, 1 = alarm,
//  2 = stopwatch, 3 = countdown at default size). Takes raw next/prev buttons
//  and debounces them in-block. Short presses step the mode; a long press on
//  next returns to mode 0. After an idle timeout the block falls back to mode 0.
//  Drives the mode select for display muxing and setting logic.
// PARAMETERS
//  NUM_MODES    4     number of modes, 2..16; legal mode values 0..NUM_MODES-1
//  MODE_W       2     width of mode output; must satisfy 2**MODE_W >= NUM_MODES
//  DEB_CYCLES   20    consecutive stable cycles to accept a key level change, >=1
//  LONG_CYCLES  1000  debounced hold length (cycles) that makes a press "long", >DEB_CYCLES
//  IDLE_TIMEOUT 0     cycles without key activity before auto-return to 0; 0 = disabled
//  WRAP         1     1: wrap around at the ends; 0: saturate at 0 / NUM_MODES-1
// PORTS
//  clk          in   1          single system clock
//  rst          in   1          asynchronous reset, active-high
//  key_next     in   1          raw button, active-high, asynchronous to clk
//  key_prev     in   1          raw button, active-high, asynchronous to clk
//  lock         in   1          1 = steps and long press ignored (e.g. while editing a value)
//  mode         out  MODE_W     current mode, registered
//  mode_onehot  out  NUM_MODES  one-hot decode of mode, registered
//  mode_chg     out  1          1-cycle pulse on the cycle mode takes a new value
//  long_press   out  1          1-cycle pulse when a next-key hold reaches LONG_CYCLES
// BEHAVIOUR
//  Reset: asynchronous. mode=0, mode_onehot=1, mode_chg=0, long_press=0.
//   Synchronisers, debounced levels and all counters clear; key FSMs go to IDLE.
//  Input path (per key): 2-FF synchroniser, then debounce.
//   - Debounced level toggles when the synced input differs from it for
//     DEB_CYCLES consecutive cycles.
//   - Any agreeing cycle clears the debounce counter.
//  Key FSM (per key): IDLE -> HELD on debounced rise; HELD counts up.
//   - next key, HELD:
//     - Count reaches LONG_CYCLES: go to LONG, pulse long_press, set mode=0.
//     - Debounced fall first: short press; step +1; go to IDLE.
//   - next key, LONG: stays until debounced fall, then IDLE; no step on that release.
//   - prev key: no LONG state. Debounced fall from HELD = step -1, any hold length.
//  Step timing: mode updates on the cycle after the debounced fall or the long event.
//   mode_chg is asserted in the same cycle as the new mode value.
//  Stepping: +1 from NUM_MODES-1 -> 0 if WRAP=1, else holds. -1 from 0 ->
//   NUM_MODES-1 if WRAP=1, else holds. A held value gives no mode_chg.
//  Simultaneous: next step and prev step in the same cycle cancel, no mode_chg.
//   A long event in the same cycle as a prev step wins: mode=0.
//  lock=1: key FSMs keep tracking, so a release under lock is consumed.
//   - No step, no long_press, no mode change; idle timer is held at 0.
//  Idle timeout (IDLE_TIMEOUT>0): counter clears whenever either debounced level is 1.
//   - Otherwise it increments while mode!=0.
//   - Reaching IDLE_TIMEOUT: mode=0, mode_chg=1, counter clears.
//   - No counting while mode==0.
//  mode_chg never asserts when the new value equals the old one.
//   Long press or timeout while already in 0: no pulse.
//  mode_onehot always equals 1<<mode.
// TESTING  (NUM_MODES=4, DEB_CYCLES=4, LONG_CYCLES=16, IDLE_TIMEOUT=64, WRAP=1)
//  1 Reset mid-hold of key_next -> next cycle mode=0, onehot=4'b0001; after release no step.
//  2 key_next pulses 3 cycles (glitch) -> no change. Four clean 8-cycle presses ->
//    mode 1,2,3,0, each with one mode_chg pulse.
//  3 key_prev press from 0 -> mode=3. Same with WRAP=0 -> mode stays 0, no mode_chg.
//  4 mode=2, hold key_next 30 cycles -> long_press pulse, mode=0, no step on release.
//  5 mode=1, next and prev released on the same cycle -> mode stays 1.
//    Press with lock=1 -> no change.
//  6 mode=3, idle 64 cycles -> mode=0, one mode_chg. Then idle 200 more -> no further pulses.

Source files
------------

// File: rtl/mode_select.sv
// Front-panel mode sequencer: debounced next/prev keys step the mode,
// a long next press or an idle timeout returns to mode 0.
module mode_select #(
  parameter int NUM_MODES    = 4,
  parameter int MODE_W       = 2,
  parameter int DEB_CYCLES   = 20,
  parameter int LONG_CYCLES  = 1000,
  parameter int IDLE_TIMEOUT = 0,
  parameter int WRAP         = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_next,
  input  logic                 key_prev,
  input  logic                 lock,
  output logic [MODE_W-1:0]    mode,
  output logic [NUM_MODES-1:0] mode_onehot,
  output logic                 mode_chg,
  output logic                 long_press
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam int IW = (IDLE_TIMEOUT > 0) ?
                      $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    N_IDLE,
    N_HELD,
    N_LONG
  } nstate_t;

  logic [1:0]         s1_q, s2_q;
  logic [1:0]         deb_q, deb_d;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;
  nstate_t            nst_q, nst_d;
  logic [LW-1:0]      hold_q, hold_d;
  logic               pheld_q, pheld_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [NUM_MODES-1:0] oh_q, oh_d;
  logic               chg_q, chg_d;
  logic               lp_q, lp_d;

  logic step_n, step_p, long_ev;
  logic inc, dec, lng;
  logic [MODE_W-1:0] nxt_val, prv_val;

  // index 0 = next key, index 1 = prev key
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      deb_d[k]  = deb_q[k];
      dcnt_d[k] = '0;
      if (s2_q[k] != deb_q[k]) begin
        if (dcnt_q[k] == DW'(DEB_CYCLES - 1))
          deb_d[k] = ~deb_q[k];
        else
          dcnt_d[k] = dcnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    nst_d   = nst_q;
    hold_d  = hold_q;
    step_n  = 1'b0;
    long_ev = 1'b0;
    unique case (nst_q)
      N_IDLE: begin
        if (deb_q[0]) begin
          nst_d  = N_HELD;
          hold_d = LW'(1);
        end
      end
      N_HELD: begin
        if (!deb_q[0]) begin
          step_n = 1'b1;
          nst_d  = N_IDLE;
          hold_d = '0;
        end else if (hold_q == LW'(LONG_CYCLES - 1)) begin
          long_ev = 1'b1;
          nst_d   = N_LONG;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      N_LONG: begin
        if (!deb_q[0]) nst_d = N_IDLE;
      end
      default: nst_d = N_IDLE;
    endcase
  end

  // prev has no long state: any debounced fall is a step
  assign pheld_d = deb_q[1];
  assign step_p  = pheld_q & ~deb_q[1];

  assign inc = step_n & ~lock;
  assign dec = step_p & ~lock;
  assign lng = long_ev & ~lock;

  always_comb begin
    nxt_val = mode_q + 1'b1;
    prv_val = mode_q - 1'b1;
    if (mode_q == MODE_W'(NUM_MODES - 1))
      nxt_val = (WRAP != 0) ? '0 : mode_q;
    if (mode_q == '0)
      prv_val = (WRAP != 0) ? MODE_W'(NUM_MODES - 1) : mode_q;
  end

  always_comb begin
    mode_d = mode_q;
    idle_d = '0;
    if (lng)
      mode_d = '0;
    else if (inc && !dec)
      mode_d = nxt_val;
    else if (dec && !inc)
      mode_d = prv_val;
    if (IDLE_TIMEOUT > 0) begin
      if (lock || (|deb_q) || mode_q == '0) begin
        idle_d = '0;
      end else if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
        idle_d = '0;
        mode_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
    chg_d = (mode_d != mode_q);
    oh_d  = NUM_MODES'(1) << mode_d;
    lp_d  = lng;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      dcnt_q  <= '0;
      nst_q   <= N_IDLE;
      hold_q  <= '0;
      pheld_q <= 1'b0;
      idle_q  <= '0;
      mode_q  <= '0;
      oh_q    <= NUM_MODES'(1);
      chg_q   <= 1'b0;
      lp_q    <= 1'b0;
    end else begin
      s1_q    <= {key_prev, key_next};
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      nst_q   <= nst_d;
      hold_q  <= hold_d;
      pheld_q <= pheld_d;
      idle_q  <= idle_d;
      mode_q  <= mode_d;
      oh_q    <= oh_d;
      chg_q   <= chg_d;
      lp_q    <= lp_d;
    end
  end

  assign mode        = mode_q;
  assign mode_onehot = oh_q;
  assign mode_chg    = chg_q;
  assign long_press  = lp_q;

endmodule
